masked_inv_up_pipe: RTL and testbench
=====================================

# masked_inv_up_pipe

Parametrised, pipelined second-order (3-share) evaluation of the two "up" coordinate functions of the masked GF(2^4) inversion layer for LANES parallel nibbles. It computes all 9 cross-share terms per coordinate function, registers them, and compresses them to 3 output shares. It uses a valid/ready handshake with backpressure and sits between the shared GF(2^4) linear map and the next inversion stage of the masked AES S-box datapath.

## Interface
- LANES, 4: number of independent nibbles processed per transfer (1..16).
- NCF, 2: coordinate functions computed per lane. 1 = f0 only; 2 = f0 and f1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input transfer request.
- in_ready  out  1  stage 1 can accept input.
- x1, x2, x3  in  4*LANES  input shares; lane l occupies bits [4l+3:4l] as {d,c,b,a}, with a at bit 0.
- r  in  3*NCF*LANES  fresh randomness; lane l uses bits [3*NCF*l +: 3*NCF].
- out_valid  out  1  output shares valid.
- out_ready  in  1  downstream accepts output.
- q1, q2, q3  out  NCF*LANES  output shares; bit [NCF*l+f] carries coordinate function f of lane l.

## Operation
- Unmasked targets per lane: f0 = b^d^ac^bc^ad; f1 = a^b^c^d^bc^ad^bd.
- Term t_f(i,j), i,j in 1..3:
  - Uses a, b from share i and c, d from share j.
  - Quadratic part for f0: a_i c_j ^ b_i c_j ^ a_i d_j.
  - Quadratic part for f1: b_i c_j ^ a_i d_j ^ b_i d_j. Terms (3,1) and (3,3) of f1 additionally contain a_3 b_3.
- Linear parts for f0:
  - (1,1) a1^c1; (1,2) b1^c2^d2; (1,3) a1^d3.
  - (2,1) a2^c1; (2,2) none; (2,3) a2^b2^c3^d3.
  - (3,1) a3^d1; (3,2) c2; (3,3) a3^b3^c3^d3.
- Linear parts for f1:
  - (1,1) c1; (1,2) a1^b1^d2; (1,3) c3^d3.
  - (2,1) d1; (2,2) none; (2,3) a2^b2^c3^d3.
  - (3,1) b3; (3,2) c2; (3,3) a3^c3^d3.
- Lane randomness, local index k = 0..5:
  - k0 is added to t0(1,2) and t0(2,1); k1 to t0(1,3) and t0(3,1); k2 to t0(2,3) and t0(3,2).
  - k3..k5 do the same for t1 at the same positions.
  - When NCF=1, only k0..k2 exist.
- Stage 1 registers all 9*NCF*LANES terms. Terms are computed only from input ports.
- Stage 2 compresses row-wise: q_i = t(i,1)^t(i,2)^t(i,3), registered into the output register.
- No combinational path from input ports to q*.
- q1^q2^q3 equals the unmasked f for every lane. The randomness cancels.

## Timing
- Reset (rst_n=0 at a clock edge):
  - Stage 1 valid, out_valid, all term registers and q1..q3 clear to 0.
  - in_ready is 1 in the cycle after reset.
  - In-flight data is discarded.
- Input transfer occurs when in_valid && in_ready. x*, r are sampled at that edge.
- Output transfer occurs when out_valid && out_ready.
- Latency: an accepted input appears on q* with out_valid=1 two cycles after acceptance, when unstalled.
- Throughput: one transfer per cycle while out_ready=1.
- Ready and advance rules:
  - out_ready combinationally affects in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready.
  - Stage 1 advances into the output register when s1_valid && (!out_valid || out_ready).
- Stall: while out_valid && !out_ready, q* and out_valid hold. Stage 1 holds if it is full.
- Held registers must not toggle, and no data register loads without a transfer. This avoids share-recombining transitions.
- Simultaneous accept and output-advance in the same cycle is legal. Both registers update.
- Empty pipe with in_valid=0: out_valid falls after the last output transfer. q* keep their last value.
- rst_n low overrides every handshake in that cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, q*=0; in_ready=1 the cycle after release.
- Zero input: LANES=4, NCF=2, all shares 0, r=0 -> two cycles later q1=q2=q3=0.
- Unmasked 0xF, lane 0: x1=0x3, x2=0x6, x3=0xA, r random -> q1^q2^q3 lane 0 gives f0=1, f1=1.
- Unmasked 0x5, lane 1: shares 0x9, 0xC, 0x0, r random -> lane 1 gives f0=1, f1=0.
- Backpressure: stream 8 transfers, out_ready=0 for cycles 3-6 -> no loss or duplication, in order; q* stable while stalled; in_ready=0 when both stages are full.
- Exhaustive sweep, NCF=1: all 16 unmasked values, random shares and r, 10^4 transfers -> XOR of shares matches f0 every time; mid-stream reset drains with no stale output.

Source files
------------

// File: rtl/masked_inv_up_pipe.sv
// Second-order (3-share) masked evaluation of the two "up" coordinate functions of the
// GF(2^4) inversion layer: stage 1 registers all cross-share terms, stage 2 compresses rows.
module masked_inv_up_pipe #(
  parameter int LANES = 4,
  parameter int NCF   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*LANES-1:0]       x1,
  input  logic [4*LANES-1:0]       x2,
  input  logic [4*LANES-1:0]       x3,
  input  logic [3*NCF*LANES-1:0]   r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCF*LANES-1:0]     q1,
  output logic [NCF*LANES-1:0]     q2,
  output logic [NCF*LANES-1:0]     q3
);

  localparam int TW = 9 * NCF * LANES;

  // Handshake: a transfer happens on a rising edge where valid && ready; data is sampled
  // at that edge, and registers holding un-transferred data never change.
  logic                   r_s1_valid;
  logic                   r_out_valid;
  logic [TW-1:0]          r_t;
  logic [TW-1:0]          w_t;
  logic [NCF*LANES-1:0]   r_q1, r_q2, r_q3;
  logic [NCF*LANES-1:0]   w_q1, w_q2, w_q3;
  logic                   w_acc;
  logic                   w_adv;

  // Nine terms t(i,j) of one coordinate function, flattened as bit 3*(i-1)+(j-1).
  function automatic logic [8:0] lane_terms(input logic [3:0] s1, input logic [3:0] s2,
                                            input logic [3:0] s3, input logic [2:0] k,
                                            input int f);
    logic [2:0] a, b, c, d;
    logic [8:0] t;
    a = {s3[0], s2[0], s1[0]};
    b = {s3[1], s2[1], s1[1]};
    c = {s3[2], s2[2], s1[2]};
    d = {s3[3], s2[3], s1[3]};
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (f == 0) t[3*i+j] = (a[i] & c[j]) ^ (b[i] & c[j]) ^ (a[i] & d[j]);
        else        t[3*i+j] = (b[i] & c[j]) ^ (a[i] & d[j]) ^ (b[i] & d[j]);
      end
    end
    if (f == 0) begin
      t[0] = t[0] ^ a[0] ^ c[0];
      t[1] = t[1] ^ b[0] ^ c[1] ^ d[1] ^ k[0];
      t[2] = t[2] ^ a[0] ^ d[2] ^ k[1];
      t[3] = t[3] ^ a[1] ^ c[0] ^ k[0];
      t[5] = t[5] ^ a[1] ^ b[1] ^ c[2] ^ d[2] ^ k[2];
      t[6] = t[6] ^ a[2] ^ d[0] ^ k[1];
      t[7] = t[7] ^ c[1] ^ k[2];
      t[8] = t[8] ^ a[2] ^ b[2] ^ c[2] ^ d[2];
    end else begin
      // a3b3 appears in both (3,1) and (3,3) so it cancels across the row
      t[0] = t[0] ^ c[0];
      t[1] = t[1] ^ a[0] ^ b[0] ^ d[1] ^ k[0];
      t[2] = t[2] ^ c[2] ^ d[2] ^ k[1];
      t[3] = t[3] ^ d[0] ^ k[0];
      t[5] = t[5] ^ a[1] ^ b[1] ^ c[2] ^ d[2] ^ k[2];
      t[6] = t[6] ^ b[2] ^ (a[2] & b[2]) ^ k[1];
      t[7] = t[7] ^ c[1] ^ k[2];
      t[8] = t[8] ^ a[2] ^ c[2] ^ d[2] ^ (a[2] & b[2]);
    end
    return t;
  endfunction

  always_comb begin
    w_t = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int f = 0; f < NCF; f++) begin
        w_t[(l*NCF+f)*9 +: 9] = lane_terms(x1[4*l +: 4], x2[4*l +: 4], x3[4*l +: 4],
                                           r[3*NCF*l + 3*f +: 3], f);
      end
    end
  end

  always_comb begin
    w_q1 = '0;
    w_q2 = '0;
    w_q3 = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int f = 0; f < NCF; f++) begin
        w_q1[l*NCF+f] = ^r_t[(l*NCF+f)*9     +: 3];
        w_q2[l*NCF+f] = ^r_t[(l*NCF+f)*9 + 3 +: 3];
        w_q3[l*NCF+f] = ^r_t[(l*NCF+f)*9 + 6 +: 3];
      end
    end
  end

  assign w_adv    = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready = !r_s1_valid || !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_t        <= '0;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_t        <= w_t;
    end else if (w_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_q1        <= '0;
      r_q2        <= '0;
      r_q3        <= '0;
    end else if (w_adv) begin
      r_out_valid <= 1'b1;
      r_q1        <= w_q1;
      r_q2        <= w_q2;
      r_q3        <= w_q3;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign q1        = r_q1;
  assign q2        = r_q2;
  assign q3        = r_q3;

endmodule

// File: tb/tb_masked_inv_up_pipe.sv
// Bench for masked_inv_up_pipe: random masked stimulus, scoreboard of unmasked f0/f1,
// monitor checking recombined shares, ordering, stall stability and ready behaviour.
module tb_masked_inv_up_pipe;

  localparam int LANES = 4;
  localparam int NCF   = 2;
  localparam int XW    = 4 * LANES;
  localparam int RW    = 3 * NCF * LANES;
  localparam int QW    = NCF * LANES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] x1 = '0, x2 = '0, x3 = '0;
  logic [RW-1:0] r = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [QW-1:0] q1, q2, q3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int occ = 0;
  bit bp_rand = 1'b0;
  bit saw_full = 1'b0;
  bit prev_stall = 1'b0;
  logic [QW-1:0] pq1, pq2, pq3;
  logic [QW-1:0] exp_q[$];
  int            lat_q[$];

  masked_inv_up_pipe #(.LANES(LANES), .NCF(NCF)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .x3(x3), .r(r),
    .out_valid(out_valid), .out_ready(out_ready),
    .q1(q1), .q2(q2), .q3(q3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [QW-1:0] ref_f(input logic [XW-1:0] a1, input logic [XW-1:0] a2,
                                          input logic [XW-1:0] a3);
    logic [XW-1:0] u;
    logic [QW-1:0] res;
    logic a, b, c, d;
    u = a1 ^ a2 ^ a3;
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      a = u[4*l]; b = u[4*l+1]; c = u[4*l+2]; d = u[4*l+3];
      res[NCF*l]   = b ^ d ^ (a & c) ^ (b & c) ^ (a & d);
      res[NCF*l+1] = a ^ b ^ c ^ d ^ (b & c) ^ (a & d) ^ (b & d);
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [XW-1:0] a1, input logic [XW-1:0] a2,
                      input logic [XW-1:0] a3, input logic [RW-1:0] rr);
    bit done;
    done = 1'b0;
    x1 = a1; x2 = a2; x3 = a3; r = rr; in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_f(a1, a2, a3));
        lat_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready stuck at 0, required 1");
    end
  endtask

  // Random masking of a chosen unmasked vector.
  task automatic send_val(input logic [XW-1:0] u);
    logic [XW-1:0] a1, a2;
    a1 = XW'($urandom);
    a2 = XW'($urandom);
    send(a1, a2, u ^ a1 ^ a2, RW'($urandom));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_out(output logic [QW-1:0] v);
    bit got;
    got = 1'b0;
    v = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (out_valid) begin v = q1 ^ q2 ^ q3; got = 1'b1; end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_out out_valid stayed 0, required 1");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin @(posedge clk); #1; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  // ---------------- randomized backpressure ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(occ == 2 && !out_ready));
      if (!in_ready) saw_full = 1'b1;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_q", {q1, q2, q3}, {pq1, pq2, pq3});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output got=%0h required none", q1 ^ q2 ^ q3);
        end else begin
          check("f_recombined", q1 ^ q2 ^ q3, exp_q.pop_front());
          check("latency_ge2", (cyc - lat_q.pop_front()) >= 2, 1);
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      pq1 = q1; pq2 = q2; pq3 = q3;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [XW-1:0] a1, a2, a3;
    logic [QW-1:0] v;

    // Reset held two cycles with in_valid asserted.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x1 = XW'($urandom); x2 = XW'($urandom); x3 = XW'($urandom); r = RW'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_q1", q1, 0);
    check("reset_q2", q2, 0);
    check("reset_q3", q3, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Zero input, exact two-cycle latency.
    send('0, '0, '0, '0);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", out_valid, 0);
    @(negedge clk);
    check("latency_cycle2", out_valid, 1);
    check("zero_q1", q1, 0);
    check("zero_q2", q2, 0);
    check("zero_q3", q3, 0);
    @(posedge clk); #1;

    // Unmasked 0xF in lane 0.
    a1 = XW'($urandom); a2 = XW'($urandom); a3 = XW'($urandom);
    a1[3:0] = 4'h3; a2[3:0] = 4'h6; a3[3:0] = 4'hA;
    send(a1, a2, a3, RW'($urandom));
    in_valid = 1'b0;
    wait_out(v);
    check("lane0_0xF", v[1:0], 2'b11);

    // Unmasked 0x5 in lane 1.
    a1 = XW'($urandom); a2 = XW'($urandom); a3 = XW'($urandom);
    a1[7:4] = 4'h9; a2[7:4] = 4'hC; a3[7:4] = 4'h0;
    send(a1, a2, a3, RW'($urandom));
    in_valid = 1'b0;
    wait_out(v);
    check("lane1_0x5", v[3:2], 2'b01);
    idle(2);

    // Backpressure: 8 back-to-back transfers with out_ready low for four cycles.
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_val(XW'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("saw_in_ready_low", saw_full, 1);

    // Random sweep: lane 0 walks every unmasked value, random gaps and backpressure.
    bp_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      a1 = XW'($urandom);
      a1[3:0] = 4'(i);
      send_val(a1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    in_valid = 1'b0;
    bp_rand = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Mid-stream reset: in-flight data must never surface.
    for (int i = 0; i < 5; i++) send_val(XW'($urandom));
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    for (int i = 0; i < 4; i++) send_val(XW'($urandom));
    in_valid = 1'b0;
    drain();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
